// File: rtl/i2s_tx_module.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_module
// Purpose  : I2S master transmitter. Generates bck_o/lrck_o from clk_i,
//            accepts stereo pairs over valid/ready into a 1-deep holding
//            register and shifts them out MSB-first with standard I2S framing
//            (data delayed one bck after each lrck edge, left while lrck=0).
// Ports    : clk_i, rst_i (async, active high), en_i    - clock/reset/enable
//            valid_i, left_i, right_i, ready_o           - sample handshake
//            bck_o, lrck_o, dat_o                        - I2S serial outputs
//            underrun_o                                  - frame start w/o data
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_module #(
  parameter int FRAME_RES = 32,
  parameter int DATA_RES  = 24,
  parameter int BCK_DIV   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                valid_i,
  input  logic [DATA_RES-1:0] left_i,
  input  logic [DATA_RES-1:0] right_i,
  output logic                ready_o,
  output logic                bck_o,
  output logic                lrck_o,
  output logic                dat_o,
  output logic                underrun_o
);

  localparam int              C_SLOTS    = 2 * FRAME_RES;
  localparam int              C_KW       = $clog2(C_SLOTS);
  localparam int              C_DW       = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [C_KW-1:0] C_K_LAST   = C_KW'(C_SLOTS - 1);
  localparam logic [C_KW-1:0] C_K_RIGHT  = C_KW'(FRAME_RES);
  localparam logic [C_DW-1:0] C_DIV_LAST = C_DW'(BCK_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [C_DW-1:0]       r_div;
  logic                  r_bck;
  logic [C_KW-1:0]       r_k;
  logic                  r_lrck;
  logic                  r_dat;
  logic                  r_underrun;
  logic [2*DATA_RES-1:0] r_hold;
  logic                  r_hold_full;
  logic [2*DATA_RES-1:0] r_frame;

  logic                  w_wrap;
  logic                  w_fall;
  logic                  w_last;
  logic                  w_frame_start;
  logic                  w_stop;
  logic                  w_tick;
  logic                  w_accept;
  logic [C_KW-1:0]       w_k_next;
  logic [C_KW-1:0]       w_s;
  logic [C_KW-1:0]       w_p;
  logic [DATA_RES-1:0]   w_word;
  logic [DATA_RES-1:0]   w_shift;
  logic                  w_bit;

  assign ready_o    = ~r_hold_full;
  assign w_accept   = valid_i & ~r_hold_full;
  assign bck_o      = r_bck;
  assign lrck_o     = r_lrck;
  assign dat_o      = r_dat;
  assign underrun_o = r_underrun;

  // Next-state and tick strobes. A frame start is either the first enabled
  // clk out of idle or the bck fall that wraps k back to 0 while enabled;
  // the same wrapping fall with en_i low drops into idle instead.
  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_stop        = 1'b0;
    w_wrap        = (r_div == C_DIV_LAST);
    w_fall        = (r_state == ST_RUN) && w_wrap && r_bck;
    w_last        = (r_k == C_K_LAST);
    case (r_state)
      ST_IDLE: begin
        if (en_i) begin
          w_frame_start = 1'b1;
          w_state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_fall && w_last) begin
          if (en_i) begin
            w_frame_start = 1'b1;
          end else begin
            w_stop       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_tick   = w_frame_start | (w_fall & ~w_last);
    w_k_next = w_frame_start ? '0 : (r_k + C_KW'(1));
  end

  // Bit sent at tick k is slot bit k-1, which is simply the current r_k
  // (or the last slot bit when leaving idle). The old frame register is
  // used, so k=0 carries the tail of the previous frame. Shifting left by
  // the slot position puts the wanted bit at the MSB and shifts in zeros
  // for pad positions beyond DATA_RES.
  always_comb begin
    w_s = (r_state == ST_RUN) ? r_k : C_K_LAST;
    if (w_s >= C_K_RIGHT) begin
      w_p    = w_s - C_K_RIGHT;
      w_word = r_frame[DATA_RES-1:0];
    end else begin
      w_p    = w_s;
      w_word = r_frame[2*DATA_RES-1:DATA_RES];
    end
    w_shift = w_word << w_p;
    w_bit   = w_shift[DATA_RES-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div       <= '0;
      r_bck       <= 1'b0;
      r_k         <= '0;
      r_lrck      <= 1'b0;
      r_dat       <= 1'b0;
      r_underrun  <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_frame     <= '0;
    end else begin
      r_underrun <= w_frame_start & ~r_hold_full;

      // Divider runs only while active; idle holds it (and bck) at zero so
      // the first enabled clk acts as the k=0 fall.
      if (r_state == ST_RUN) begin
        r_div <= w_wrap ? '0 : (r_div + C_DW'(1));
        if (w_wrap) begin
          r_bck <= ~r_bck;
        end
      end else begin
        r_div <= '0;
        r_bck <= 1'b0;
      end

      if (w_tick) begin
        r_k    <= w_k_next;
        r_lrck <= (w_k_next >= C_K_RIGHT);
        r_dat  <= w_bit;
      end else if (w_stop) begin
        r_k    <= '0;
        r_lrck <= 1'b0;
        r_dat  <= 1'b0;
      end

      if (w_frame_start) begin
        r_frame <= r_hold_full ? r_hold : '0;
      end

      // Accept and consume are exclusive: accept needs an empty holding
      // register, consume needs a full one.
      if (w_accept) begin
        r_hold      <= {left_i, right_i};
        r_hold_full <= 1'b1;
      end else if (w_frame_start) begin
        r_hold_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx_module
// Purpose  : Directed self-checking bench for i2s_tx_module
//            (FRAME_RES=32, DATA_RES=24, BCK_DIV=2, 256 clk per frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_module;

  logic        clk;
  logic        rst;
  logic        en;
  logic        valid;
  logic [23:0] left;
  logic [23:0] right;
  logic        ready;
  logic        bck;
  logic        lrck;
  logic        dat;
  logic        underrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // bench-side decoder / driver state
  logic        pb;
  logic        plr;
  int          t0;
  int          rise_cnt;
  int          lrck_err;
  int          edge_err;
  logic [23:0] got_l [4];
  logic [23:0] got_r [4];
  logic        pad   [4];
  int          ur_off[$];
  int          acc_off[$];
  logic [23:0] drv_l [4];
  logic [23:0] drv_r [4];
  int          drv_n;
  logic        found;

  i2s_tx_module #(
    .FRAME_RES(32),
    .DATA_RES (24),
    .BCK_DIV  (2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .valid_i   (valid),
    .left_i    (left),
    .right_i   (right),
    .ready_o   (ready),
    .bck_o     (bck),
    .lrck_o    (lrck),
    .dat_o     (dat),
    .underrun_o(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs nclk negedges. The first negedge is expected to follow a frame
  // start. Decodes bits on bck rises (rise j of a frame carries slot bit
  // j-1), logs underrun pulses and accepts as offsets from that first
  // negedge, drives drv_* pairs with valid held high, and optionally drops
  // en at offset drop_at.
  task automatic run_frames(input int nclk, input int drop_at);
    int  j;
    int  f;
    int  idx;
    bit  acc_pend;
    idx      = 0;
    acc_pend = 0;
    rise_cnt = 0;
    lrck_err = 0;
    edge_err = 0;
    ur_off.delete();
    acc_off.delete();
    for (int i = 0; i < 4; i++) begin
      got_l[i] = '0;
      got_r[i] = '0;
      pad[i]   = 1'b0;
    end
    pb  = bck;
    plr = lrck;
    for (int i = 0; i < nclk; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc;
      if (!pb && bck) begin
        j = rise_cnt % 64;
        f = rise_cnt / 64;
        if (lrck !== (j >= 32)) lrck_err++;
        if (f < 4) begin
          if (j >= 1 && j <= 24)       got_l[f][24-j] = dat;
          else if (j >= 33 && j <= 56) got_r[f][56-j] = dat;
          else                         pad[f] = pad[f] | dat;
        end
        rise_cnt++;
      end
      if (lrck !== plr && !(pb && !bck)) edge_err++;
      if (underrun) ur_off.push_back(cyc - t0);
      pb  = bck;
      plr = lrck;
      if (drop_at >= 0 && (cyc - t0) == drop_at) en = 1'b0;
      if (acc_pend) begin
        acc_pend = 0;
        idx++;
      end
      if (idx < drv_n) begin
        valid = 1'b1;
        left  = drv_l[idx];
        right = drv_r[idx];
      end else begin
        valid = 1'b0;
      end
      if (valid && ready) begin
        acc_pend = 1;
        acc_off.push_back(cyc + 1 - t0);
      end
    end
  endtask

  initial begin
    clk = 0; rst = 1; en = 0; valid = 0; left = '0; right = '0;
    drv_n = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_bck", bck, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_dat", dat, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", ready, 1);
    rst = 0;
    @(negedge clk);

    // load a pair while idle; handshake stays live without en
    valid = 1; left = 24'hA5A5A5; right = 24'h3C3C3C;
    @(negedge clk);
    valid = 0;
    chk("idle_accept_ready", ready, 0);
    repeat (5) @(negedge clk);
    chk("idle_outputs", {bck, lrck, dat}, 0);

    // basic transmit, then an underrun frame
    en = 1;
    run_frames(512, -1);
    chk("t2_left", got_l[0], 24'hA5A5A5);
    chk("t2_right", got_r[0], 24'h3C3C3C);
    chk("t2_pad", pad[0], 0);
    chk("t2_rises", rise_cnt, 128);
    chk("t2_lrck_level", lrck_err, 0);
    chk("t2_lrck_edge", edge_err, 0);
    chk("t2_ur_count", ur_off.size(), 1);
    chk("t2_ur_period", (ur_off.size() > 0) ? ur_off[0] : -1, 256);
    chk("t4_left_zero", got_l[1], 0);
    chk("t4_right_zero", got_r[1], 0);
    chk("t4_pad_zero", pad[1], 0);

    // underrun frame with en dropped at k=10; a pair arrives mid-frame
    drv_n = 1; drv_l[0] = 24'h800001; drv_r[0] = 24'h7FFFFE;
    run_frames(400, 40);
    chk("t6_ur_count", ur_off.size(), 1);
    chk("t6_ur_at_start", (ur_off.size() > 0) ? ur_off[0] : -1, 0);
    chk("t6_accept_off", (acc_off.size() > 0) ? acc_off[0] : -1, 1);
    chk("t6_rises", rise_cnt, 64);
    chk("t6_idle_outputs", {bck, lrck, dat}, 0);
    chk("t6_hold_kept", ready, 0);
    chk("t6_lrck_edge", edge_err, 0);

    // restart from idle with pending pair, valid held for two more pairs
    drv_n = 2;
    drv_l[0] = 24'h000000; drv_r[0] = 24'hFFFFFF;
    drv_l[1] = 24'h123456; drv_r[1] = 24'h654321;
    en = 1;
    run_frames(1024, -1);
    chk("t5_f0_left", got_l[0], 24'h800001);
    chk("t5_f0_right", got_r[0], 24'h7FFFFE);
    chk("t5_f1_left", got_l[1], 24'h000000);
    chk("t5_f1_right", got_r[1], 24'hFFFFFF);
    chk("t5_f2_left", got_l[2], 24'h123456);
    chk("t5_f2_right", got_r[2], 24'h654321);
    chk("t5_f3_left", got_l[3], 0);
    chk("t5_f3_right", got_r[3], 0);
    chk("t5_pad", {pad[0], pad[1], pad[2], pad[3]}, 0);
    chk("t5_acc_count", acc_off.size(), 2);
    chk("t5_acc0", (acc_off.size() > 0) ? acc_off[0] : -1, 1);
    chk("t5_acc1", (acc_off.size() > 1) ? acc_off[1] : -1, 257);
    chk("t5_ur_count", ur_off.size(), 1);
    chk("t5_ur_off", (ur_off.size() > 0) ? ur_off[0] : -1, 768);
    chk("t5_rises", rise_cnt, 256);
    chk("t5_lrck_level", lrck_err, 0);
    chk("t5_lrck_edge", edge_err, 0);

    // asynchronous reset mid-frame with bck, lrck and dat all high
    valid = 1; left = 24'h000000; right = 24'hFFFFFF;
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      if (bck && lrck && dat && !ready) found = 1;
    end
    chk("t1_setup_found", found, 1);
    valid = 0;
    #2;
    rst = 1;
    #1;
    chk("t1_bck", bck, 0);
    chk("t1_lrck", lrck, 0);
    chk("t1_dat", dat, 0);
    chk("t1_underrun", underrun, 0);
    chk("t1_ready", ready, 1);
    en = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
